// File: rtl/ether_arp_rx_if.sv
// GMII receive bus plus the ARP request and debug counter outputs of ether_arp_rx.
// The slave side is the detector; the master side is whatever feeds it PHY bytes.
interface ether_arp_rx_if;
  logic        phy_rx_dv;
  logic        phy_rx_er;
  logic [7:0]  phy_rx_data;
  logic        arp_req;
  logic [47:0] arp_sha;
  logic [31:0] arp_spa;
  logic [15:0] rx_frames;
  logic [15:0] rx_crc_err;

  modport master (
    output phy_rx_dv, phy_rx_er, phy_rx_data,
    input  arp_req, arp_sha, arp_spa, rx_frames, rx_crc_err
  );

  modport slave (
    input  phy_rx_dv, phy_rx_er, phy_rx_data,
    output arp_req, arp_sha, arp_spa, rx_frames, rx_crc_err
  );
endinterface

// File: rtl/ether_arp_rx.sv
// GMII receive-side ARP request detector: strips preamble/SFD, checks FCS and length,
// parses Ethernet/ARP headers in flight and pulses arp_req for requests aimed at MY_IP.
module ether_arp_rx #(
  parameter logic [31:0] MY_IP   = 32'h0A001563,
  parameter logic [47:0] MY_MAC  = 48'h00301BA0A499,
  parameter int          MIN_LEN = 64,
  parameter int          MAX_LEN = 1522
) (
  input  logic           clk_125,
  input  logic           rst,
  ether_arp_rx_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, FRAME, DROP} state_t;

  localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
  localparam logic [10:0] IDX_MAX = 11'd2047;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  state_t      state, state_nxt;
  logic        dv_q, er_q;
  logic [7:0]  data_q;

  logic        frame_start, frame_byte, frame_end;
  logic [10:0] byte_idx;
  logic [31:0] crc;
  logic        match_flag, da_bc_ok, da_my_ok, er_flag;
  logic [47:0] sha_sh;
  logic [31:0] spa_sh;

  logic        hdr_chk, da_chk;
  logic [7:0]  hdr_exp, da_exp;
  logic        crc_ok, len_ok, arp_ok;

  logic        arp_req_r;
  logic [47:0] arp_sha_r;
  logic [31:0] arp_spa_r;
  logic [15:0] rx_frames_r, rx_crc_err_r;

  // Reflected CRC-32, one byte per call, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_ff @(posedge clk_125 or posedge rst) begin
    if (rst) begin
      dv_q   <= 1'b0;
      er_q   <= 1'b0;
      data_q <= 8'h00;
    end else begin
      dv_q   <= bus.phy_rx_dv;
      er_q   <= bus.phy_rx_er;
      data_q <= bus.phy_rx_data;
    end
  end

  always_ff @(posedge clk_125 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_byte  = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE: begin
        if (dv_q) state_nxt = (data_q == 8'h55) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!dv_q)                 state_nxt = IDLE;
        else if (data_q == 8'h55)  state_nxt = PREAMBLE;
        else if (data_q == 8'hD5) begin
          state_nxt   = FRAME;
          frame_start = 1'b1;
        end else                   state_nxt = DROP;
      end
      FRAME: begin
        if (dv_q) frame_byte = 1'b1;
        else begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end
      end
      DROP: begin
        if (!dv_q) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Expected byte at each fixed header position of an Ethernet II ARP request.
  always_comb begin
    hdr_chk = 1'b0;
    hdr_exp = 8'h00;
    case (byte_idx)
      11'd12: begin hdr_chk = 1'b1; hdr_exp = 8'h08; end
      11'd13: begin hdr_chk = 1'b1; hdr_exp = 8'h06; end
      11'd14: begin hdr_chk = 1'b1; hdr_exp = 8'h00; end
      11'd15: begin hdr_chk = 1'b1; hdr_exp = 8'h01; end
      11'd16: begin hdr_chk = 1'b1; hdr_exp = 8'h08; end
      11'd17: begin hdr_chk = 1'b1; hdr_exp = 8'h00; end
      11'd18: begin hdr_chk = 1'b1; hdr_exp = 8'h06; end
      11'd19: begin hdr_chk = 1'b1; hdr_exp = 8'h04; end
      11'd20: begin hdr_chk = 1'b1; hdr_exp = 8'h00; end
      11'd21: begin hdr_chk = 1'b1; hdr_exp = 8'h01; end
      11'd38: begin hdr_chk = 1'b1; hdr_exp = MY_IP[31:24]; end
      11'd39: begin hdr_chk = 1'b1; hdr_exp = MY_IP[23:16]; end
      11'd40: begin hdr_chk = 1'b1; hdr_exp = MY_IP[15:8];  end
      11'd41: begin hdr_chk = 1'b1; hdr_exp = MY_IP[7:0];   end
      default: ;
    endcase
  end

  always_comb begin
    da_chk = 1'b1;
    da_exp = 8'h00;
    case (byte_idx)
      11'd0:   da_exp = MY_MAC[47:40];
      11'd1:   da_exp = MY_MAC[39:32];
      11'd2:   da_exp = MY_MAC[31:24];
      11'd3:   da_exp = MY_MAC[23:16];
      11'd4:   da_exp = MY_MAC[15:8];
      11'd5:   da_exp = MY_MAC[7:0];
      default: da_chk = 1'b0;
    endcase
  end

  // Per-frame datapath: CRC, byte index, header match tracking and field shadows.
  always_ff @(posedge clk_125 or posedge rst) begin
    if (rst) begin
      byte_idx   <= 11'd0;
      crc        <= 32'hFFFFFFFF;
      match_flag <= 1'b0;
      da_bc_ok   <= 1'b0;
      da_my_ok   <= 1'b0;
      er_flag    <= 1'b0;
      sha_sh     <= 48'h0;
      spa_sh     <= 32'h0;
    end else if (frame_start) begin
      byte_idx   <= 11'd0;
      crc        <= 32'hFFFFFFFF;
      match_flag <= 1'b1;
      da_bc_ok   <= 1'b1;
      da_my_ok   <= 1'b1;
      er_flag    <= 1'b0;
    end else if (frame_byte) begin
      crc     <= crc32_byte(crc, data_q);
      er_flag <= er_flag | er_q;
      if (byte_idx != IDX_MAX) byte_idx <= byte_idx + 11'd1;
      if (da_chk && data_q != 8'hFF)   da_bc_ok   <= 1'b0;
      if (da_chk && data_q != da_exp)  da_my_ok   <= 1'b0;
      if (hdr_chk && data_q != hdr_exp) match_flag <= 1'b0;
      if (byte_idx >= 11'd22 && byte_idx <= 11'd27) sha_sh <= {sha_sh[39:0], data_q};
      if (byte_idx >= 11'd28 && byte_idx <= 11'd31) spa_sh <= {spa_sh[23:0], data_q};
    end
  end

  assign crc_ok = (crc == RESIDUE);
  assign len_ok = (byte_idx >= MIN_L) && (byte_idx <= MAX_L);
  assign arp_ok = match_flag && (da_bc_ok || da_my_ok);

  // End-of-frame verdict; errored frames leave every counter alone.
  always_ff @(posedge clk_125 or posedge rst) begin
    if (rst) begin
      arp_req_r    <= 1'b0;
      arp_sha_r    <= 48'h0;
      arp_spa_r    <= 32'h0;
      rx_frames_r  <= 16'h0;
      rx_crc_err_r <= 16'h0;
    end else begin
      arp_req_r <= 1'b0;
      if (frame_end && !er_flag) begin
        if (!crc_ok) begin
          if (rx_crc_err_r != 16'hFFFF) rx_crc_err_r <= rx_crc_err_r + 16'd1;
        end else if (len_ok) begin
          if (rx_frames_r != 16'hFFFF) rx_frames_r <= rx_frames_r + 16'd1;
          if (arp_ok) begin
            arp_req_r <= 1'b1;
            arp_sha_r <= sha_sh;
            arp_spa_r <= spa_sh;
          end
        end
      end
    end
  end

  assign bus.arp_req    = arp_req_r;
  assign bus.arp_sha    = arp_sha_r;
  assign bus.arp_spa    = arp_spa_r;
  assign bus.rx_frames  = rx_frames_r;
  assign bus.rx_crc_err = rx_crc_err_r;

endmodule

// File: tb/tb_ether_arp_rx.sv
// Directed bench for ether_arp_rx: builds ARP frames with their FCS and checks
// pulse timing, captured fields and counters against hand-derived values.
module tb_ether_arp_rx;

  localparam logic [47:0] BCAST  = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] MY_MAC = 48'h00301BA0A499;
  localparam logic [31:0] MY_IP  = 32'h0A001563;

  logic clk_125 = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   pulse_cnt = 0;
  int   p0;
  logic [7:0] frm[$];

  ether_arp_rx_if bus();

  ether_arp_rx dut (
    .clk_125 (clk_125),
    .rst     (rst),
    .bus     (bus)
  );

  always #4 clk_125 = ~clk_125;

  always @(negedge clk_125) begin
    if (bus.arp_req === 1'b1) pulse_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ARP request padded to ndata bytes, followed by its FCS (complemented CRC, LSB first).
  task automatic buildFrame(input logic [47:0] da, input logic [47:0] sha,
                            input logic [31:0] spa, input logic [31:0] tpa, input int ndata);
    logic [31:0] c;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(da[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(sha[47-8*i -: 8]);
    frm.push_back(8'h08); frm.push_back(8'h06);
    frm.push_back(8'h00); frm.push_back(8'h01);
    frm.push_back(8'h08); frm.push_back(8'h00);
    frm.push_back(8'h06); frm.push_back(8'h04);
    frm.push_back(8'h00); frm.push_back(8'h01);
    for (int i = 0; i < 6; i++) frm.push_back(sha[47-8*i -: 8]);
    for (int i = 0; i < 4; i++) frm.push_back(spa[31-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(8'h00);
    for (int i = 0; i < 4; i++) frm.push_back(tpa[31-8*i -: 8]);
    while (frm.size() < ndata) frm.push_back(8'h00);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < frm.size(); i++) begin
      c = c ^ {24'h0, frm[i]};
      for (int b = 0; b < 8; b++) c = {1'b0, c[31:1]} ^ (32'hEDB88320 & {32{c[0]}});
    end
    c = ~c;
    frm.push_back(c[7:0]);   frm.push_back(c[15:8]);
    frm.push_back(c[23:16]); frm.push_back(c[31:24]);
  endtask

  // Drives npre preamble bytes, optional SFD, the frame, then one idle cycle.
  task automatic applyStimulus(input int npre, input bit sfd, input int er_idx,
                               input int flip_idx, input int rst_idx);
    for (int i = 0; i < npre; i++) begin
      @(negedge clk_125);
      bus.phy_rx_dv = 1'b1; bus.phy_rx_er = 1'b0; bus.phy_rx_data = 8'h55;
    end
    if (sfd) begin
      @(negedge clk_125);
      bus.phy_rx_dv = 1'b1; bus.phy_rx_er = 1'b0; bus.phy_rx_data = 8'hD5;
    end
    for (int i = 0; i < frm.size(); i++) begin
      @(negedge clk_125);
      bus.phy_rx_dv   = 1'b1;
      bus.phy_rx_data = (i == flip_idx) ? (frm[i] ^ 8'h10) : frm[i];
      bus.phy_rx_er   = (i == er_idx);
      rst             = (i == rst_idx);
    end
    @(negedge clk_125);
    bus.phy_rx_dv = 1'b0; bus.phy_rx_er = 1'b0; bus.phy_rx_data = 8'h00; rst = 1'b0;
  endtask

  // Call right after applyStimulus: next edge is E, pulse must show only after E+1.
  task automatic checkEof(input string tag, input logic exp_req);
    @(posedge clk_125);
    @(posedge clk_125); #1;
    checkOutput({tag, " req@E+1"}, 48'(bus.arp_req), 48'(exp_req));
    @(posedge clk_125); #1;
    checkOutput({tag, " req@E+2"}, 48'(bus.arp_req), 48'h0);
  endtask

  initial begin
    rst = 1'b1;
    bus.phy_rx_dv = 1'b0; bus.phy_rx_er = 1'b0; bus.phy_rx_data = 8'h00;
    repeat (3) @(negedge clk_125);
    rst = 1'b0;
    @(negedge clk_125);
    checkOutput("rst arp_req",    48'(bus.arp_req),    48'h0);
    checkOutput("rst arp_sha",    bus.arp_sha,         48'h0);
    checkOutput("rst arp_spa",    48'(bus.arp_spa),    48'h0);
    checkOutput("rst rx_frames",  48'(bus.rx_frames),  48'h0);
    checkOutput("rst rx_crc_err", 48'(bus.rx_crc_err), 48'h0);

    $display("[TB] good broadcast request");
    p0 = pulse_cnt;
    buildFrame(BCAST, 48'h00301BA0A48E, 32'h0A00150A, MY_IP, 60);
    applyStimulus(7, 1, -1, -1, -1);
    checkEof("good", 1'b1);
    checkOutput("good sha",    bus.arp_sha,             48'h00301BA0A48E);
    checkOutput("good spa",    48'(bus.arp_spa),        48'h0A00150A);
    checkOutput("good frames", 48'(bus.rx_frames),      48'd1);
    checkOutput("good crcerr", 48'(bus.rx_crc_err),     48'd0);
    checkOutput("good pulses", 48'(pulse_cnt - p0),     48'd1);

    $display("[TB] payload bit flipped");
    applyStimulus(7, 1, -1, 50, -1);
    checkEof("flip", 1'b0);
    checkOutput("flip crcerr", 48'(bus.rx_crc_err), 48'd1);
    checkOutput("flip frames", 48'(bus.rx_frames),  48'd1);

    $display("[TB] request for another host");
    buildFrame(BCAST, 48'h00301BA0A4AA, 32'h0A00150B, 32'h0A00150A, 60);
    applyStimulus(7, 1, -1, -1, -1);
    checkEof("other", 1'b0);
    checkOutput("other frames", 48'(bus.rx_frames), 48'd2);
    checkOutput("other sha",    bus.arp_sha,        48'h00301BA0A48E);
    checkOutput("other spa",    48'(bus.arp_spa),   48'h0A00150A);

    $display("[TB] rx_er during frame");
    buildFrame(BCAST, 48'h00301BA0A48E, 32'h0A00150A, MY_IP, 60);
    applyStimulus(7, 1, 30, -1, -1);
    checkEof("er", 1'b0);
    checkOutput("er frames", 48'(bus.rx_frames),  48'd2);
    checkOutput("er crcerr", 48'(bus.rx_crc_err), 48'd1);

    $display("[TB] SFD without preamble, then good frame");
    p0 = pulse_cnt;
    applyStimulus(0, 1, -1, -1, -1);
    buildFrame(BCAST, 48'h00301BA0A4AA, 32'h0A00150B, MY_IP, 60);
    applyStimulus(7, 1, -1, -1, -1);
    checkEof("nopre", 1'b1);
    checkOutput("nopre frames", 48'(bus.rx_frames),  48'd3);
    checkOutput("nopre pulses", 48'(pulse_cnt - p0), 48'd1);
    checkOutput("nopre sha",    bus.arp_sha,         48'h00301BA0A4AA);
    checkOutput("nopre spa",    48'(bus.arp_spa),    48'h0A00150B);

    $display("[TB] back-to-back frames, one idle cycle");
    p0 = pulse_cnt;
    buildFrame(BCAST, 48'h00301BA0A48E, 32'h0A00150A, MY_IP, 60);
    applyStimulus(7, 1, -1, -1, -1);
    buildFrame(BCAST, 48'h00301BA0A4BB, 32'h0A00150C, MY_IP, 60);
    applyStimulus(7, 1, -1, -1, -1);
    checkEof("b2b", 1'b1);
    checkOutput("b2b frames", 48'(bus.rx_frames),  48'd5);
    checkOutput("b2b pulses", 48'(pulse_cnt - p0), 48'd2);
    checkOutput("b2b sha",    bus.arp_sha,         48'h00301BA0A4BB);
    checkOutput("b2b spa",    48'(bus.arp_spa),    48'h0A00150C);

    $display("[TB] length boundaries and DA filter");
    buildFrame(MY_MAC, 48'h00301BA0A4CC, 32'h0A00150D, MY_IP, 59);
    applyStimulus(7, 1, -1, -1, -1);
    checkEof("len63", 1'b0);
    checkOutput("len63 frames", 48'(bus.rx_frames),  48'd5);
    checkOutput("len63 crcerr", 48'(bus.rx_crc_err), 48'd1);
    buildFrame(MY_MAC, 48'h00301BA0A4CC, 32'h0A00150D, MY_IP, 60);
    applyStimulus(7, 1, -1, -1, -1);
    checkEof("ucast", 1'b1);
    checkOutput("ucast frames", 48'(bus.rx_frames), 48'd6);
    checkOutput("ucast sha",    bus.arp_sha,        48'h00301BA0A4CC);
    buildFrame(48'h00301BA0A4FF, 48'h00301BA0A4DD, 32'h0A00150E, MY_IP, 60);
    applyStimulus(7, 1, -1, -1, -1);
    checkEof("otherda", 1'b0);
    checkOutput("otherda frames", 48'(bus.rx_frames), 48'd7);
    checkOutput("otherda sha",    bus.arp_sha,        48'h00301BA0A4CC);
    buildFrame(BCAST, 48'h00301BA0A4EE, 32'h0A00150F, MY_IP, 1518);
    applyStimulus(7, 1, -1, -1, -1);
    checkEof("len1522", 1'b1);
    checkOutput("len1522 frames", 48'(bus.rx_frames), 48'd8);
    buildFrame(BCAST, 48'h00301BA0A411, 32'h0A001510, MY_IP, 1519);
    applyStimulus(7, 1, -1, -1, -1);
    checkEof("len1523", 1'b0);
    checkOutput("len1523 frames", 48'(bus.rx_frames), 48'd8);
    buildFrame(BCAST, 48'h00301BA0A422, 32'h0A001511, MY_IP, 2100);
    applyStimulus(7, 1, -1, -1, -1);
    checkEof("huge", 1'b0);
    checkOutput("huge frames", 48'(bus.rx_frames),  48'd8);
    checkOutput("huge crcerr", 48'(bus.rx_crc_err), 48'd1);
    checkOutput("huge sha",    bus.arp_sha,         48'h00301BA0A4EE);

    $display("[TB] reset in the middle of a frame");
    buildFrame(BCAST, 48'h00301BA0A48E, 32'h0A00150A, MY_IP, 60);
    applyStimulus(7, 1, -1, -1, 25);
    checkEof("midrst", 1'b0);
    checkOutput("midrst sha",    bus.arp_sha,         48'h0);
    checkOutput("midrst spa",    48'(bus.arp_spa),    48'h0);
    checkOutput("midrst frames", 48'(bus.rx_frames),  48'd0);
    checkOutput("midrst crcerr", 48'(bus.rx_crc_err), 48'd0);
    applyStimulus(7, 1, -1, -1, -1);
    checkEof("afterrst", 1'b1);
    checkOutput("afterrst frames", 48'(bus.rx_frames), 48'd1);
    checkOutput("afterrst sha",    bus.arp_sha,        48'h00301BA0A48E);
    checkOutput("afterrst spa",    48'(bus.arp_spa),   48'h0A00150A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
